// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the key debouncer.
// The optional IRQ capture (KEY_DEBOUNCE_IRQ_EN) lives in the top module;
// nothing here depends on it.
package key_debounce_pkg;

    // Per-channel debounce state: idle/settled, or counting a candidate level.
    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } deb_state_e;

    // 20 ms at 50 MHz; 20 bits holds 999_999.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int CNT_WIDTH_DEFAULT       = 20;

    // Level a key reads when it is not pressed.
    function automatic logic idle_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stable-count FSM and
// registered press/release pulses. The FSM state is visible on state_dbg.
//
// Timing: a raw edge sampled at clock edge 1 reaches sync after edge 2; the
// FSM enters CHANGING at edge 3 and accepts the new level at edge
// DEBOUNCE_CYCLES+3, which is also the cycle the event pulse appears.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_raw,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output deb_state_e state_dbg
);

    localparam logic                 IDLE     = idle_level(ACTIVE_LOW != 0);
    localparam logic                 PRESSED  = ~IDLE;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 ff1_q;
    logic                 ff2_q;
    logic                 sync;
    deb_state_e           state_q;
    deb_state_e           state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 level_q;
    logic                 level_d;
    logic                 press_q;
    logic                 press_d;
    logic                 release_q;
    logic                 release_d;

    // Two-flop synchronizer; resets to the idle level so no false event
    // is seen straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff1_q <= IDLE;
            ff2_q <= IDLE;
        end else begin
            ff1_q <= key_raw;
            ff2_q <= ff1_q;
        end
    end

    assign sync = ff2_q;

    // FSM, counter, debounced level and event pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= STABLE;
            cnt_q     <= '0;
            level_q   <= IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Next-state logic. The counter only advances while sync disagrees with
    // the accepted level, and the level flips at CNT_LAST, so the counter
    // can never wrap. Any agreement while CHANGING cancels the candidate.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            STABLE: begin
                if (sync != level_q) begin
                    state_d = CHANGING;
                end
            end
            CHANGING: begin
                if (sync == level_q) begin
                    state_d = STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    level_d = sync;
                    if (sync == PRESSED) begin
                        press_d = 1'b1;
                    end else begin
                        release_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
            end
        endcase
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign state_dbg     = state_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner in front of the key PIO: NUM_KEYS independent
// debounce channels producing a clean level plus press/release pulses.
// Optional macro KEY_DEBOUNCE_IRQ_EN adds a sticky per-key press capture
// (write-1-to-clear via irq_clear, set wins) and a registered irq output.
// state_dbg bit k is 1 while channel k is counting a candidate level.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
`ifdef KEY_DEBOUNCE_IRQ_EN
    input  logic [NUM_KEYS-1:0] irq_clear,
    output logic                irq,
`endif
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] state_dbg
);

    // Parameter sanity: at least two cycles, and the counter must hold
    // DEBOUNCE_CYCLES-1.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (64'(DEBOUNCE_CYCLES - 1) >= (64'd1 << CNT_WIDTH)) begin : g_bad_width
        $error("key_debounce: CNT_WIDTH too small for DEBOUNCE_CYCLES-1");
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        deb_state_e chan_state;

        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_raw       (key_raw[gi]),
            .key_level     (key_level[gi]),
            .press_pulse   (press_pulse[gi]),
            .release_pulse (release_pulse[gi]),
            .state_dbg     (chan_state)
        );

        assign state_dbg[gi] = (chan_state == CHANGING);
    end

`ifdef KEY_DEBOUNCE_IRQ_EN
    logic [NUM_KEYS-1:0] cap_q;
    logic [NUM_KEYS-1:0] cap_d;
    logic                irq_q;

    // Sticky capture: a press sets its bit, irq_clear clears it, and a
    // press arriving with the clear keeps the bit set.
    always_comb begin
        cap_d = (cap_q & ~irq_clear) | press_pulse;
    end

    // Capture and irq registers; irq follows the updated capture so it
    // rises one cycle after the press pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            irq_q <= |cap_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Randomized and directed bench for key_debounce (NUM_KEYS=2,
// DEBOUNCE_CYCLES=8, CNT_WIDTH=4, ACTIVE_LOW=1). The reference model tracks,
// per key, how many consecutive synchronized samples disagreed with the
// accepted level; DEBOUNCE_CYCLES+1 in a row means the level is accepted.
// Handshake: none; inputs change on the falling edge, outputs are checked
// 1 ns after the rising edge.
module tb_key_debounce;
    localparam int NK = 2;
    localparam int DC = 8;
    localparam int CW = 4;
    localparam logic [NK-1:0] IDLE_V  = '1;
    localparam logic          PRESSED = 1'b0;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_n;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_level;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] state_dbg;
`ifdef KEY_DEBOUNCE_IRQ_EN
    logic [NK-1:0] irq_clear;
    logic          irq;
`endif

    always #5 clk = ~clk;

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .CNT_WIDTH       (CW),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_raw       (key_raw),
`ifdef KEY_DEBOUNCE_IRQ_EN
        .irq_clear     (irq_clear),
        .irq           (irq),
`endif
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [NK-1:0]     m_level;
    logic [NK-1:0]     m_press;
    logic [NK-1:0]     m_rel;
    int                m_run [NK];
    logic [NK-1:0]     sync_q [$];    // raw samples in flight through the synchronizer
    logic [3*NK-1:0]   exp_q [$];     // expected {level, press, release} per edge
    logic [NK-1:0]     m_cap;
    logic              m_irq;

    task automatic model_reset();
        m_level = IDLE_V;
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < NK; k++) m_run[k] = 0;
        sync_q.delete();
        sync_q.push_back(IDLE_V);
        sync_q.push_back(IDLE_V);
        exp_q.delete();
        m_cap = '0;
        m_irq = 1'b0;
    endtask

    // One rising edge of the reference: raw sampled now is seen two edges later.
    task automatic model_edge(input logic [NK-1:0] raw, input logic [NK-1:0] clr);
        logic [NK-1:0] s;
        s = sync_q.pop_front();
        sync_q.push_back(raw);
        m_cap = (m_cap & ~clr) | m_press;
        m_irq = |m_cap;
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < NK; k++) begin
            if (s[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == DC + 1) begin
                    m_level[k] = s[k];
                    m_run[k]   = 0;
                    if (s[k] == PRESSED) m_press[k] = 1'b1;
                    else                 m_rel[k]   = 1'b1;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        exp_q.push_back({m_level, m_press, m_rel});
    endtask

    // ---------------- driver ----------------
    // Called on a falling edge; drives inputs, runs one rising edge,
    // compares against the model and returns on the next falling edge.
    task automatic step(input logic [NK-1:0] raw, input logic [NK-1:0] clr);
        logic [3*NK-1:0] e;
        key_raw = raw;
`ifdef KEY_DEBOUNCE_IRQ_EN
        irq_clear = clr;
`endif
        @(posedge clk);
        model_edge(raw, clr);
        #1;
        e = exp_q.pop_front();
        check("level",   key_level,     e[3*NK-1 -: NK]);
        check("press",   press_pulse,   e[2*NK-1 -: NK]);
        check("release", release_pulse, e[NK-1:0]);
        check("excl",    press_pulse & release_pulse, '0);
`ifdef KEY_DEBOUNCE_IRQ_EN
        check("irq", irq, m_irq);
`endif
        @(negedge clk);
    endtask

    task automatic hold(input logic [NK-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int idx;
        int n_press;
        int n_rel;
        int n_any;
        int rem [NK];
        logic [NK-1:0] r;

        reset_n = 1'b0;
        key_raw = IDLE_V;
`ifdef KEY_DEBOUNCE_IRQ_EN
        irq_clear = '0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_level",   key_level,     IDLE_V);
        check("rst_press",   press_pulse,   '0);
        check("rst_release", release_pulse, '0);
        check("rst_state",   state_dbg,     '0);
`ifdef KEY_DEBOUNCE_IRQ_EN
        check("rst_irq", irq, 1'b0);
`endif
        reset_n = 1'b1;
        hold(IDLE_V, 3);

        // Press key0: level falls at edge 11, one-cycle pulse.
        for (int i = 1; i <= 20; i++) begin
            step(2'b10, '0);
            if (i == 10) check("press_pre",  key_level,   2'b11);
            if (i == 11) check("press_lvl",  key_level,   2'b10);
            if (i == 11) check("press_puls", press_pulse, 2'b01);
            if (i == 12) check("press_one",  press_pulse, 2'b00);
        end

        // Release key0.
        for (int i = 1; i <= 20; i++) begin
            step(2'b11, '0);
            if (i == 11) check("rel_puls", release_pulse, 2'b01);
            if (i == 11) check("rel_lvl",  key_level,     2'b11);
        end

        // Bounce: low 5, high 2, low 20 -> fall 11 edges after step 8.
        idx = 0; n_press = 0; n_rel = 0;
        for (int i = 1; i <= 27; i++) begin
            step((i <= 5 || i >= 8) ? 2'b10 : 2'b11, '0);
            n_press += int'(press_pulse[0]);
            n_rel   += int'(release_pulse[0]);
            if (idx == 0 && key_level[0] == 1'b0) idx = i;
        end
        check("bounce_edge",  idx,     18);
        check("bounce_press", n_press, 1);
        check("bounce_rel",   n_rel,   0);
        hold(2'b11, 20);

        // Glitch on key1: four low cycles are rejected.
        n_any = 0;
        for (int i = 1; i <= 19; i++) begin
            step((i <= 4) ? 2'b01 : 2'b11, '0);
            n_any += int'(|(press_pulse | release_pulse));
        end
        check("glitch_pulses", n_any, 0);
        check("glitch_level", key_level, 2'b11);

        // Simultaneous press on both keys.
        for (int i = 1; i <= 20; i++) begin
            step(2'b00, '0);
            if (i == 11) check("both_press", press_pulse, 2'b11);
        end
        hold(2'b11, 20);

`ifdef KEY_DEBOUNCE_IRQ_EN
        step(2'b11, 2'b11);
        idx = 0;
        for (int i = 1; i <= 20 && idx == 0; i++) begin
            step(2'b01, '0);
            if (press_pulse[1]) idx = i;
        end
        check("irq_press_seen", idx, 11);
        step(2'b01, 2'b00);
        check("irq_set", irq, 1'b1);
        step(2'b01, 2'b10);
        check("irq_clr", irq, 1'b0);
        hold(2'b11, 20);
        idx = 0;
        for (int i = 1; i <= 20 && idx == 0; i++) begin
            step(2'b01, '0);
            if (press_pulse[1]) idx = i;
        end
        step(2'b01, 2'b10);
        check("irq_set_wins", irq, 1'b1);
        step(2'b01, 2'b00);
        check("irq_sticky", irq, 1'b1);
        hold(2'b11, 20);
        step(2'b11, 2'b11);
`endif

        // Reset mid-CHANGING with key0 pressed and key1 counting.
        hold(2'b10, 20);
        hold(2'b00, 6);
        #2 reset_n = 1'b0;
        #1;
        check("arst_level",   key_level,     IDLE_V);
        check("arst_press",   press_pulse,   '0);
        check("arst_release", release_pulse, '0);
        check("arst_state",   state_dbg,     '0);
`ifdef KEY_DEBOUNCE_IRQ_EN
        check("arst_irq", irq, 1'b0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        idx = 0; n_any = 0;
        for (int i = 1; i <= 20; i++) begin
            step(2'b00, '0);
            if (idx == 0 && press_pulse != 2'b00) idx = i;
            n_any += int'(|release_pulse);
        end
        check("arst_latency", idx, 11);
        check("arst_no_rel", n_any, 0);

        // Random hold lengths around the acceptance threshold.
        r = key_raw;
        for (int k = 0; k < NK; k++) rem[k] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NK; k++) begin
                if (rem[k] == 0) begin
                    r[k]   = 1'($urandom_range(0, 1));
                    rem[k] = $urandom_range(1, 14);
                end
                rem[k]--;
            end
            step(r, NK'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
